// File: rtl/atm_module.sv
// ATM session controller: card check, PIN entry with lockout, menu transactions
// (balance, withdraw, deposit, PIN change), inactivity timeout and card-removal abort.
module atm_module #(
  parameter int TIMEOUT_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        card_inserted,
  input  logic [7:0]  card_number_input,
  input  logic [15:0] pin_input,
  input  logic        balance_req,
  input  logic        withdrawal_req,
  input  logic        deposit_req,
  input  logic        pin_change_req,
  input  logic [15:0] amount,
  input  logic        transaction_done,
  output logic [7:0]  current_state,
  output logic [15:0] balance,
  output logic        transaction_success,
  output logic [7:0]  error_code
);

  typedef enum logic [7:0] {
    ST_IDLE       = 8'h00,
    ST_CARD_CHECK = 8'h01,
    ST_PIN_ENTRY  = 8'h02,
    ST_MENU       = 8'h03,
    ST_BALANCE    = 8'h04,
    ST_WITHDRAW   = 8'h05,
    ST_DEPOSIT    = 8'h06,
    ST_PIN_CHANGE = 8'h07,
    ST_TXN_DONE   = 8'h08,
    ST_ERROR      = 8'h09
  } state_t;

  localparam logic [7:0] ERR_NONE     = 8'h00;
  localparam logic [7:0] ERR_CARD     = 8'h01;
  localparam logic [7:0] ERR_PIN      = 8'h02;
  localparam logic [7:0] ERR_BLOCKED  = 8'h03;
  localparam logic [7:0] ERR_FUNDS    = 8'h04;
  localparam logic [7:0] ERR_TIMEOUT  = 8'h05;
  localparam logic [7:0] ERR_REMOVED  = 8'h06;
  localparam logic [7:0] ERR_OVERFLOW = 8'h07;
  localparam logic [7:0] ERR_NEW_PIN  = 8'h08;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  function automatic logic [15:0] reset_pin(input logic [1:0] idx);
    case (idx)
      2'd0:    reset_pin = 16'h1234;
      2'd1:    reset_pin = 16'h5678;
      2'd2:    reset_pin = 16'h9999;
      2'd3:    reset_pin = 16'h4321;
      default: reset_pin = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] reset_bal(input logic [1:0] idx);
    case (idx)
      2'd0:    reset_bal = 16'h03E8;
      2'd1:    reset_bal = 16'h01F4;
      2'd2:    reset_bal = 16'h0000;
      2'd3:    reset_bal = 16'h2710;
      default: reset_bal = 16'h0000;
    endcase
  endfunction

  // Card 2 is provisioned inactive; indices beyond the table are never valid.
  function automatic logic card_active(input logic [7:0] idx);
    card_active = (idx < 8'd4) && (idx != 8'd2);
  endfunction

  state_t         state_r, state_next_s;
  logic [7:0]     card_idx_r;
  logic [15:0]    pin_mem_r [4];
  logic [15:0]    bal_mem_r [4];
  logic [3:0]     blocked_r;
  logic [1:0]     attempts_r, attempts_next_s;
  logic [TW-1:0]  timer_r, timer_next_s;
  logic [15:0]    pin_prev_r, amount_r, new_pin_r;
  logic           session_r, session_next_s;
  logic [15:0]    balance_r, balance_next_s;
  logic           success_r, success_next_s;
  logic [7:0]     error_r, error_next_s;

  logic [1:0]     sel_s;
  logic [15:0]    cur_bal_s, cur_pin_s, bal_wdata_s;
  logic [16:0]    sum_s;
  logic           any_req_s, pin_changed_s, timed_s;
  logic           bal_we_s, pin_we_s, block_set_s, latch_card_s, latch_req_s;

  assign sel_s         = card_idx_r[1:0];
  assign cur_bal_s     = bal_mem_r[sel_s];
  assign cur_pin_s     = pin_mem_r[sel_s];
  assign sum_s         = {1'b0, cur_bal_s} + {1'b0, amount_r};
  assign any_req_s     = balance_req | withdrawal_req | deposit_req | pin_change_req;
  assign pin_changed_s = (pin_input != pin_prev_r);
  assign timed_s       = (state_r == ST_PIN_ENTRY) || (state_r == ST_MENU) || (state_r == ST_TXN_DONE);

  // Next-state, status and card-table write decisions.
  always_comb begin
    state_next_s    = state_r;
    error_next_s    = error_r;
    success_next_s  = success_r;
    attempts_next_s = attempts_r;
    session_next_s  = session_r;
    timer_next_s    = '0;
    bal_we_s        = 1'b0;
    bal_wdata_s     = cur_bal_s;
    pin_we_s        = 1'b0;
    block_set_s     = 1'b0;
    latch_card_s    = 1'b0;
    latch_req_s     = 1'b0;

    // Card pulled mid-session overrides everything else.
    if (!card_inserted && (state_r != ST_IDLE) && (state_r != ST_ERROR)) begin
      state_next_s   = ST_IDLE;
      error_next_s   = ERR_REMOVED;
      success_next_s = 1'b0;
      session_next_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (card_inserted) begin
            state_next_s   = ST_CARD_CHECK;
            latch_card_s   = 1'b1;
            error_next_s   = ERR_NONE;
            success_next_s = 1'b0;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_CARD_CHECK: begin
          attempts_next_s = 2'd0;
          if (!card_active(card_idx_r)) begin
            state_next_s = ST_ERROR;
            error_next_s = ERR_CARD;
          end else if (blocked_r[sel_s]) begin
            state_next_s = ST_ERROR;
            error_next_s = ERR_BLOCKED;
          end else begin
            state_next_s = ST_PIN_ENTRY;
          end
        end
        ST_PIN_ENTRY: begin
          if (pin_input == cur_pin_s) begin
            state_next_s   = ST_MENU;
            session_next_s = 1'b1;
            error_next_s   = ERR_NONE;
          end else if ((pin_input != 16'h0000) && pin_changed_s) begin
            if (attempts_r == 2'd2) begin
              block_set_s  = 1'b1;
              state_next_s = ST_ERROR;
              error_next_s = ERR_BLOCKED;
            end else begin
              attempts_next_s = attempts_r + 2'd1;
              error_next_s    = ERR_PIN;
            end
          end else begin
            state_next_s = ST_PIN_ENTRY;
          end
        end
        ST_MENU: begin
          latch_req_s = any_req_s;
          if (balance_req) begin
            state_next_s = ST_BALANCE;
          end else if (withdrawal_req) begin
            state_next_s = ST_WITHDRAW;
          end else if (deposit_req) begin
            state_next_s = ST_DEPOSIT;
          end else if (pin_change_req) begin
            state_next_s = ST_PIN_CHANGE;
          end else begin
            state_next_s = ST_MENU;
          end
        end
        ST_BALANCE: begin
          state_next_s   = ST_TXN_DONE;
          success_next_s = 1'b1;
          error_next_s   = ERR_NONE;
        end
        ST_WITHDRAW: begin
          state_next_s = ST_TXN_DONE;
          if ((amount_r != 16'h0000) && (amount_r <= cur_bal_s)) begin
            bal_we_s       = 1'b1;
            bal_wdata_s    = cur_bal_s - amount_r;
            success_next_s = 1'b1;
            error_next_s   = ERR_NONE;
          end else begin
            success_next_s = 1'b0;
            error_next_s   = ERR_FUNDS;
          end
        end
        ST_DEPOSIT: begin
          state_next_s = ST_TXN_DONE;
          if (amount_r == 16'h0000) begin
            success_next_s = 1'b0;
            error_next_s   = ERR_FUNDS;
          end else if (sum_s[16]) begin
            success_next_s = 1'b0;
            error_next_s   = ERR_OVERFLOW;
          end else begin
            bal_we_s       = 1'b1;
            bal_wdata_s    = sum_s[15:0];
            success_next_s = 1'b1;
            error_next_s   = ERR_NONE;
          end
        end
        ST_PIN_CHANGE: begin
          state_next_s = ST_TXN_DONE;
          if (new_pin_r != 16'h0000) begin
            pin_we_s       = 1'b1;
            success_next_s = 1'b1;
            error_next_s   = ERR_NONE;
          end else begin
            success_next_s = 1'b0;
            error_next_s   = ERR_NEW_PIN;
          end
        end
        ST_TXN_DONE: begin
          if (transaction_done) begin
            state_next_s   = ST_MENU;
            success_next_s = 1'b0;
            error_next_s   = ERR_NONE;
          end else begin
            state_next_s = ST_TXN_DONE;
          end
        end
        ST_ERROR: begin
          if (!card_inserted) begin
            state_next_s   = ST_IDLE;
            success_next_s = 1'b0;
            session_next_s = 1'b0;
          end else begin
            state_next_s = ST_ERROR;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase

      // Inactivity timer restarts on any user activity or state change.
      if ((state_next_s != state_r) || pin_changed_s || any_req_s) begin
        timer_next_s = '0;
      end else if (timed_s) begin
        if (timer_r == TW'(TIMEOUT_CYCLES - 1)) begin
          state_next_s = ST_ERROR;
          error_next_s = ERR_TIMEOUT;
          timer_next_s = '0;
        end else begin
          timer_next_s = timer_r + TW'(1'b1);
        end
      end else begin
        timer_next_s = '0;
      end
    end
  end

  assign balance_next_s = session_next_s ? (bal_we_s ? bal_wdata_s : cur_bal_s) : 16'h0000;

  // State, status outputs and persistent card table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      card_idx_r <= 8'h00;
      blocked_r  <= 4'b0000;
      attempts_r <= 2'd0;
      timer_r    <= '0;
      pin_prev_r <= 16'h0000;
      amount_r   <= 16'h0000;
      new_pin_r  <= 16'h0000;
      session_r  <= 1'b0;
      balance_r  <= 16'h0000;
      success_r  <= 1'b0;
      error_r    <= ERR_NONE;
      for (int i = 0; i < 4; i++) begin
        pin_mem_r[i] <= reset_pin(2'(i));
        bal_mem_r[i] <= reset_bal(2'(i));
      end
    end else begin
      state_r    <= state_next_s;
      attempts_r <= attempts_next_s;
      timer_r    <= timer_next_s;
      session_r  <= session_next_s;
      balance_r  <= balance_next_s;
      success_r  <= success_next_s;
      error_r    <= error_next_s;
      pin_prev_r <= (state_r == ST_CARD_CHECK) ? 16'h0000 : pin_input;
      if (latch_card_s) card_idx_r <= card_number_input;
      if (latch_req_s) begin
        amount_r  <= amount;
        new_pin_r <= pin_input;
      end
      if (bal_we_s)    bal_mem_r[sel_s] <= bal_wdata_s;
      if (pin_we_s)    pin_mem_r[sel_s] <= new_pin_r;
      if (block_set_s) blocked_r[sel_s] <= 1'b1;
    end
  end

  assign current_state       = state_r;
  assign balance             = balance_r;
  assign transaction_success = success_r;
  assign error_code          = error_r;

endmodule

// File: tb/tb_atm_module.sv
// Transaction-level bench for atm_module: directed scenarios plus random sessions
// scored against an account-table model (balances, PINs, blocked flags).
module tb_atm_module;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        card_inserted = 1'b0;
  logic [7:0]  card_number_input = 8'h00;
  logic [15:0] pin_input = 16'h0000;
  logic        balance_req = 1'b0, withdrawal_req = 1'b0, deposit_req = 1'b0, pin_change_req = 1'b0;
  logic [15:0] amount = 16'h0000;
  logic        transaction_done = 1'b0;
  logic [7:0]  current_state;
  logic [15:0] balance;
  logic        transaction_success;
  logic [7:0]  error_code;

  localparam logic [7:0] S_IDLE = 8'h00, S_PIN = 8'h02, S_MENU = 8'h03,
                         S_WDR = 8'h05, S_TXN = 8'h08, S_ERR = 8'h09;

  atm_module #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .card_inserted(card_inserted),
    .card_number_input(card_number_input), .pin_input(pin_input),
    .balance_req(balance_req), .withdrawal_req(withdrawal_req),
    .deposit_req(deposit_req), .pin_change_req(pin_change_req),
    .amount(amount), .transaction_done(transaction_done),
    .current_state(current_state), .balance(balance),
    .transaction_success(transaction_success), .error_code(error_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Account model
  logic [15:0] m_pin [4];
  logic [15:0] m_bal [4];
  bit          m_blk [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pin[0] = 16'h1234; m_bal[0] = 16'h03E8;
    m_pin[1] = 16'h5678; m_bal[1] = 16'h01F4;
    m_pin[2] = 16'h9999; m_bal[2] = 16'h0000;
    m_pin[3] = 16'h4321; m_bal[3] = 16'h2710;
    for (int i = 0; i < 4; i++) m_blk[i] = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [7:0] st, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (current_state == st) break;
    end
    check_val(tag, current_state, st);
  endtask

  task automatic insert_card(input logic [7:0] c, output bit ok, output logic [7:0] err);
    card_number_input = c;
    pin_input = 16'h0000;
    card_inserted = 1'b1;
    if (c > 8'd3 || c == 8'd2) begin
      wait_state("ins_invalid", S_ERR, 4);
      check_val("err_invalid", error_code, 8'h01);
      ok = 1'b0; err = 8'h01;
    end else if (m_blk[c[1:0]]) begin
      wait_state("ins_blocked", S_ERR, 4);
      check_val("err_blocked", error_code, 8'h03);
      ok = 1'b0; err = 8'h03;
    end else begin
      wait_state("ins_ok", S_PIN, 4);
      check_val("ins_err", error_code, 8'h00);
      check_val("ins_bal", balance, 16'h0000);
      ok = 1'b1; err = 8'h00;
    end
  endtask

  task automatic enter_pin(input logic [1:0] c, input logic [15:0] p);
    pin_input = p;
    wait_state("pin_menu", S_MENU, 3);
    check_val("pin_bal", balance, m_bal[c]);
    check_val("pin_err", error_code, 8'h00);
  endtask

  task automatic wrong_pin(input logic [15:0] p, input bit last);
    pin_input = p;
    @(negedge clk);
    if (last) begin
      check_val("wrong_state", current_state, S_ERR);
      check_val("wrong_err", error_code, 8'h03);
    end else begin
      check_val("wrong_state", current_state, S_PIN);
      check_val("wrong_err", error_code, 8'h02);
    end
  endtask

  task automatic remove_card(input logic [7:0] exp_err);
    card_inserted = 1'b0;
    @(negedge clk);
    check_val("rm_state", current_state, S_IDLE);
    check_val("rm_err", error_code, exp_err);
    check_val("rm_bal", balance, 16'h0000);
  endtask

  // kind: 0 balance, 1 withdraw, 2 deposit, 3 PIN change
  task automatic menu_op(input logic [1:0] c, input int kind, input logic [15:0] v);
    bit succ;
    logic [7:0] err;
    int sum;
    succ = 1'b1; err = 8'h00;
    case (kind)
      1: begin
        if (v != 16'h0000 && v <= m_bal[c]) m_bal[c] = m_bal[c] - v;
        else begin succ = 1'b0; err = 8'h04; end
      end
      2: begin
        sum = int'(m_bal[c]) + int'(v);
        if (v == 16'h0000) begin succ = 1'b0; err = 8'h04; end
        else if (sum > 65535) begin succ = 1'b0; err = 8'h07; end
        else m_bal[c] = 16'(sum);
      end
      3: begin
        if (v != 16'h0000) m_pin[c] = v;
        else begin succ = 1'b0; err = 8'h08; end
      end
      default: ;
    endcase
    amount = v;
    if (kind == 3) pin_input = v;
    balance_req    = (kind == 0);
    withdrawal_req = (kind == 1);
    deposit_req    = (kind == 2);
    pin_change_req = (kind == 3);
    @(negedge clk);
    {balance_req, withdrawal_req, deposit_req, pin_change_req} = 4'b0000;
    wait_state("op_txn", S_TXN, 4);
    check_val("op_succ", transaction_success, succ);
    check_val("op_err", error_code, err);
    check_val("op_bal", balance, m_bal[c]);
    transaction_done = 1'b1;
    @(negedge clk);
    transaction_done = 1'b0;
    check_val("done_state", current_state, S_MENU);
    check_val("done_succ", transaction_success, 1'b0);
    check_val("done_err", error_code, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [7:0] err, c;
    logic [15:0] wp, v;
    int kind, nops;

    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_state", current_state, S_IDLE);
    check_val("rst_bal", balance, 16'h0000);
    check_val("rst_succ", transaction_success, 1'b0);
    check_val("rst_err", error_code, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Card 0 login and basic transactions
    insert_card(8'd0, ok, err);
    enter_pin(2'd0, 16'h1234);
    check_val("c0_bal_abs", balance, 16'h03E8);
    menu_op(2'd0, 1, 16'h0050);
    check_val("c0_after_wdr", balance, 16'h0398);
    menu_op(2'd0, 1, 16'h1000);
    menu_op(2'd0, 2, 16'h0100);
    check_val("c0_after_dep", balance, 16'h0498);
    remove_card(8'h06);

    // Card 1 timeout with no PIN entered
    insert_card(8'd1, ok, err);
    repeat (19) @(negedge clk);
    check_val("to_before", current_state, S_PIN);
    @(negedge clk);
    check_val("to_state", current_state, S_ERR);
    check_val("to_err", error_code, 8'h05);
    remove_card(8'h05);

    // Card 1 lockout after three wrong PINs
    insert_card(8'd1, ok, err);
    wrong_pin(16'h1111, 1'b0);
    wrong_pin(16'h2222, 1'b0);
    wrong_pin(16'h3333, 1'b1);
    m_blk[1] = 1'b1;
    remove_card(8'h03);
    insert_card(8'd1, ok, err);
    remove_card(8'h03);

    // Inactive card, then deposit overflow on card 3
    insert_card(8'd2, ok, err);
    remove_card(8'h01);
    insert_card(8'd3, ok, err);
    enter_pin(2'd3, 16'h4321);
    menu_op(2'd3, 2, 16'hF000);
    remove_card(8'h06);

    // Random sessions
    for (int s = 0; s < 40; s++) begin
      c = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      insert_card(c, ok, err);
      if (ok) begin
        if ($urandom_range(0, 2) == 0) begin
          wp = (m_pin[c[1:0]] == 16'h0101) ? 16'h0202 : (m_pin[c[1:0]] ^ 16'h0101);
          wrong_pin(wp, 1'b0);
        end
        enter_pin(c[1:0], m_pin[c[1:0]]);
        nops = $urandom_range(1, 4);
        for (int k = 0; k < nops; k++) begin
          kind = $urandom_range(0, 3);
          case ($urandom_range(0, 3))
            0:       v = 16'h0000;
            1:       v = 16'($urandom_range(1, 65535));
            default: v = 16'($urandom_range(1, 32'(m_bal[c[1:0]]) + 1));
          endcase
          if (kind == 2 && $urandom_range(0, 1) == 1) v = 16'(65536 - int'(m_bal[c[1:0]]) + int'($urandom_range(0, 15)));
          menu_op(c[1:0], kind, v);
        end
        remove_card(8'h06);
      end else begin
        remove_card(err);
      end
    end

    // Asynchronous reset in the middle of a withdrawal restores the table
    insert_card(8'd0, ok, err);
    enter_pin(2'd0, m_pin[0]);
    amount = 16'h0010;
    withdrawal_req = 1'b1;
    @(negedge clk);
    withdrawal_req = 1'b0;
    check_val("mid_wdr", current_state, S_WDR);
    #2;
    rst_n = 1'b0;
    card_inserted = 1'b0;
    #1;
    check_val("arst_state", current_state, S_IDLE);
    check_val("arst_bal", balance, 16'h0000);
    check_val("arst_err", error_code, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    insert_card(8'd0, ok, err);
    enter_pin(2'd0, 16'h1234);
    check_val("restored_bal", balance, 16'h03E8);
    remove_card(8'h06);
    insert_card(8'd1, ok, err);
    check_val("unblocked", current_state, S_PIN);
    remove_card(8'h06);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_module.md
ATM_MODULE -- requirements
Module: atm_module

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, reset. One clock; reset is asynchronous and active-low.
REQ-002 card_inserted input 1: card present level.
REQ-003 card_number_input input 8: card index, latched in IDLE on card_inserted rise.
REQ-004 pin_input input 16: BCD PIN; 16'h0000 = no entry; also the new PIN for PIN change.
REQ-005 balance_req, withdrawal_req, deposit_req, pin_change_req input 1 each: menu requests, level-sampled in MENU.
REQ-006 amount input 16: unsigned amount, sampled in the cycle a withdraw/deposit request is accepted.
REQ-007 transaction_done input 1: user acknowledge, exits TXN_COMPLETE.
REQ-008 current_state output 8, balance output 16, transaction_success output 1, error_code output 8, all registered.
REQ-009 Parameter TIMEOUT_CYCLES, default 20: inactivity limit.

Function
REQ-010 Card table, 4 entries, reset values: 0: PIN 1234, balance 0x03E8, active; 1: PIN 5678, 0x01F4, active; 2: PIN 9999, 0x0000, inactive; 3: PIN 4321, 0x2710, active. Per-card blocked flag, reset 0.
REQ-011 State codes: IDLE 00, CARD_CHECK 01, PIN_ENTRY 02, MENU 03, BALANCE 04, WITHDRAW 05, DEPOSIT 06, PIN_CHANGE 07, TXN_COMPLETE 08, ERROR 09; current_state = state code.
REQ-012 Error codes: 00 none, 01 invalid/inactive card, 02 wrong PIN, 03 card blocked, 04 insufficient funds or zero amount, 05 timeout, 06 card removed, 07 deposit overflow, 08 invalid new PIN (0x0000).
REQ-013 IDLE: card_inserted=1 -> CARD_CHECK next cycle, latch card index, clear error_code.
REQ-014 CARD_CHECK (1 cycle): index>3 or inactive -> ERROR/01; blocked -> ERROR/03; else PIN_ENTRY, attempts=0.
REQ-015 PIN_ENTRY: pin_input equal to stored PIN -> MENU next cycle. Nonzero mismatch counts one attempt when first seen and on every change of value, error_code=02; third attempt -> set blocked flag, ERROR/03.
REQ-016 MENU: request priority balance > withdrawal > deposit > pin_change; go to matching state, latch amount/pin_input.
REQ-017 BALANCE (1 cycle): success=1 -> TXN_COMPLETE.
REQ-018 WITHDRAW (1 cycle): amount!=0 and amount<=balance -> subtract, success=1; else error 04, balance unchanged, success=0; -> TXN_COMPLETE.
REQ-019 DEPOSIT (1 cycle): amount!=0 and sum<=0xFFFF -> add, success=1; zero -> error 04; carry out -> error 07, unchanged; -> TXN_COMPLETE.
REQ-020 PIN_CHANGE (1 cycle): latched PIN nonzero -> store, success=1; else error 08; -> TXN_COMPLETE.
REQ-021 TXN_COMPLETE: hold success/error; transaction_done=1 -> MENU, success cleared, error_code cleared.
REQ-022 Timeout: counter in PIN_ENTRY, MENU, TXN_COMPLETE; cleared on state change, pin_input change, any request; reaching TIMEOUT_CYCLES -> ERROR/05.
REQ-023 ERROR: hold error_code; leave only on card_inserted=0 -> IDLE.
REQ-024 card_inserted=0 in any state except IDLE/ERROR -> IDLE next cycle, error_code=06 (held until next insertion); highest priority after reset.
REQ-025 balance = selected card's balance from PIN acceptance until IDLE entry; else 0. Balances/PINs persist across sessions.

Reset
REQ-026 rst_n=0 asynchronously: state IDLE, all outputs 0, card table to REQ-010 values, blocked flags/attempts/timer 0.

Verification
REQ-027 Reset, card 0, pin 0x1234 -> MENU within 3 cycles, balance 0x03E8, error 00.
REQ-028 From MENU withdraw 0x0050 -> TXN_COMPLETE, success=1, balance 0x0398; transaction_done -> MENU, success 0.
REQ-029 Withdraw 0x1000 with balance 0x0398 -> error 04, success 0, balance unchanged; deposit 0x0100 -> balance 0x0498.
REQ-030 Card 1, pin held 0x0000 -> ERROR/05 after 20 cycles; card 1, pins 0x1111,0x2222,0x3333 -> ERROR/03; reinsert card 1 -> ERROR/03.
REQ-031 Card 2 -> ERROR/01; card_inserted=0 -> IDLE; card 3 deposit 0xF000 on 0x2710 -> error 07.
REQ-032 card_inserted=0 in MENU -> IDLE, error 06, balance 0; async rst_n mid-WITHDRAW -> IDLE, balances restored.
